// File: rtl/cpu_clock_ctrl_if.sv
// Control/status bundle between the step/mode front end and the CPU clock controller.
// master drives the requests, slave (the controller) drives the clock enables and queue status.
interface cpu_clock_ctrl_if #(
  parameter int PEND_W = 3
);
  logic              step_pulse;
  logic              run_mode;
  logic              halt;
  logic              cpu_ce;
  logic              phi2;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output step_pulse,
    output run_mode,
    output halt,
    input  cpu_ce,
    input  phi2,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  step_pulse,
    input  run_mode,
    input  halt,
    output cpu_ce,
    output phi2,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// 6502 cycle-enable and phi2 generator: free-runs at clk_in/DIV or executes queued single steps.
// state | meaning:  IDLE | no CPU cycle in progress;  RUN | free-running period;  STEP | serving one queued step
module cpu_clock_ctrl #(
  parameter int DIV    = 50,
  parameter int PEND_W = 3
) (
  input  logic              clk_in,
  input  logic              rst,
  cpu_clock_ctrl_if.slave   bus
);

  localparam int                CNT_W    = $clog2(DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(DIV / 2);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  div_cnt;
  logic [PEND_W-1:0] pend_q;
  logic              ovf_q;

  logic              period_end;
  logic              accept;
  logic              consume;
  logic              drop;
  logic [PEND_W-1:0] pend_next;

  always_comb begin
    period_end = (state != IDLE) && (div_cnt == CNT_LAST);
    accept     = bus.step_pulse && !bus.run_mode;
    consume    = (state == STEP) && period_end;
    drop       = 1'b0;
    pend_next  = pend_q;
    // A pulse arriving on the same edge as a consumed step simply replaces it.
    if (accept && !consume) begin
      if (pend_q == PEND_MAX) begin
        drop = 1'b1;
      end else begin
        pend_next = pend_q + 1'b1;
      end
    end else if (consume && !accept) begin
      pend_next = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q <= pend_next;
      if (drop) begin
        ovf_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          div_cnt <= '0;
          if (!bus.halt) begin
            if (bus.run_mode) begin
              state <= RUN;
            end else if (pend_q != '0) begin
              state <= STEP;
            end
          end
        end
        RUN: begin
          if (period_end) begin
            div_cnt <= '0;
            if (!bus.run_mode || bus.halt) begin
              state <= IDLE;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        STEP: begin
          // Mode and halt are only looked at once the started period is complete.
          if (period_end) begin
            div_cnt <= '0;
            if (bus.run_mode || bus.halt || (pend_next == '0)) begin
              state <= IDLE;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          div_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.cpu_ce   = period_end;
  assign bus.phi2     = (state != IDLE) && (div_cnt >= CNT_HALF);
  assign bus.busy     = (state != IDLE);
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Bench for cpu_clock_ctrl: directed scenarios with literal expectations plus a randomized
// run checked every cycle against a cycle-level behavioural model of the controller.
module tb_cpu_clock_ctrl;
  localparam int DIV    = 4;
  localparam int PEND_W = 3;
  localparam int QMAX   = 7;

  logic clk_in = 1'b0;
  logic rst    = 1'b0;

  cpu_clock_ctrl_if #(.PEND_W(PEND_W)) bus ();

  cpu_clock_ctrl #(.DIV(DIV), .PEND_W(PEND_W)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic nxt();
    @(negedge clk_in);
  endtask

  // Behavioural model: active period flag, position within the period, queue depth.
  bit m_active = 1'b0;
  bit m_step   = 1'b0;
  bit m_ovf    = 1'b0;
  int m_pos    = 0;
  int m_pend   = 0;
  int np;

  always @(posedge clk_in or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_step   = 1'b0;
      m_ovf    = 1'b0;
      m_pos    = 0;
      m_pend   = 0;
    end else begin
      np = m_pend + ((bus.step_pulse && !bus.run_mode) ? 1 : 0)
                  - ((m_active && m_step && m_pos == DIV-1) ? 1 : 0);
      if (np > QMAX) begin
        np    = QMAX;
        m_ovf = 1'b1;
      end
      if (!m_active) begin
        m_pos = 0;
        if (!bus.halt && bus.run_mode) begin
          m_active = 1'b1;
          m_step   = 1'b0;
        end else if (!bus.halt && m_pend != 0) begin
          m_active = 1'b1;
          m_step   = 1'b1;
        end
      end else if (m_pos == DIV-1) begin
        m_pos    = 0;
        m_active = !bus.halt && (m_step ? (!bus.run_mode && np != 0) : bus.run_mode);
      end else begin
        m_pos = m_pos + 1;
      end
      m_pend = np;
    end
  end

  always @(negedge clk_in) begin
    if (chk_on) begin
      chk("model_cpu_ce",   int'(bus.cpu_ce),   int'(m_active && m_pos == DIV-1));
      chk("model_phi2",     int'(bus.phi2),     int'(m_active && m_pos >= DIV/2));
      chk("model_busy",     int'(bus.busy),     int'(m_active));
      chk("model_pending",  int'(bus.pending),  m_pend);
      chk("model_overflow", int'(bus.overflow), int'(m_ovf));
    end
  end

  int ce_n, ce_k, busy_n, last_k;
  int pat[4] = '{0, 0, 1, 1};

  initial begin
    bus.step_pulse = 1'b0;
    bus.run_mode   = 1'b0;
    bus.halt       = 1'b0;
    #2 rst = 1'b1;
    #20;
    nxt();
    rst    = 1'b0;
    chk_on = 1'b1;
    chk("reset_busy",     int'(bus.busy),     0);
    chk("reset_pending",  int'(bus.pending),  0);
    chk("reset_overflow", int'(bus.overflow), 0);

    // Free run: 40 cycles give 10 enables, 4 apart, phi2 = 0,0,1,1.
    bus.run_mode = 1'b1;
    ce_n = 0; last_k = -100;
    for (int i = 1; i <= 40; i++) begin
      nxt();
      chk("run_phi2_pattern", int'(bus.phi2), pat[(i-1) % 4]);
      if (bus.cpu_ce) begin
        ce_n++;
        if (last_k > 0) chk("run_ce_spacing", i - last_k, 4);
        last_k = i;
      end
    end
    chk("run_ce_count", ce_n, 10);
    bus.run_mode = 1'b0;
    nxt();
    chk("run_stop_idle", int'(bus.busy), 0);

    // Queue two steps while halted, then free-run and reset mid-period.
    bus.halt = 1'b1;
    bus.step_pulse = 1'b1;
    nxt(); nxt();
    bus.step_pulse = 1'b0;
    chk("halt_queue_two", int'(bus.pending), 2);
    bus.halt = 1'b0;
    bus.run_mode = 1'b1;
    nxt(); nxt(); nxt();
    chk("run_keeps_pending", int'(bus.pending), 2);
    chk("run_busy_before_rst", int'(bus.busy), 1);
    chk("run_phi2_before_rst", int'(bus.phi2), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_cpu_ce_now",   int'(bus.cpu_ce),   0);
    chk("rst_phi2_now",     int'(bus.phi2),     0);
    chk("rst_busy_now",     int'(bus.busy),     0);
    chk("rst_pending_now",  int'(bus.pending),  0);
    chk("rst_overflow_now", int'(bus.overflow), 0);
    nxt();
    rst = 1'b0;
    bus.run_mode = 1'b0;

    // Single step: enable 4 negedges after the sampling edge, busy for 4 cycles.
    nxt();
    bus.step_pulse = 1'b1;
    nxt();
    bus.step_pulse = 1'b0;
    chk("step_pending_one", int'(bus.pending), 1);
    ce_n = 0; ce_k = -1; busy_n = 0;
    for (int k = 1; k <= 8; k++) begin
      nxt();
      if (bus.busy) busy_n++;
      if (bus.cpu_ce) begin ce_n++; ce_k = k; end
    end
    chk("step_ce_count",   ce_n, 1);
    chk("step_ce_latency", ce_k, 4);
    chk("step_busy_len",   busy_n, 4);
    chk("step_pending_zero", int'(bus.pending), 0);

    // Nine pulses while halted saturate the queue at 7 and flag overflow.
    bus.halt = 1'b1;
    bus.step_pulse = 1'b1;
    repeat (9) nxt();
    bus.step_pulse = 1'b0;
    chk("full_pending",  int'(bus.pending),  7);
    chk("full_overflow", int'(bus.overflow), 1);
    bus.halt = 1'b0;
    ce_n = 0; ce_k = -1; busy_n = 0; last_k = -100;
    for (int k = 1; k <= 32; k++) begin
      nxt();
      if (bus.busy) busy_n++;
      if (bus.cpu_ce) begin
        ce_n++;
        if (last_k > 0) chk("drain_ce_spacing", k - last_k, 4);
        else chk("drain_first_ce", k, 4);
        last_k = k;
      end
    end
    chk("drain_ce_count", ce_n, 7);
    chk("drain_busy_len", busy_n, 28);
    chk("drain_idle",     int'(bus.busy), 0);
    chk("drain_pending",  int'(bus.pending), 0);
    chk("drain_overflow_sticky", int'(bus.overflow), 1);

    // Leave run mode at div_cnt=1: period completes, pulse in run mode ignored.
    bus.run_mode = 1'b1;
    bus.step_pulse = 1'b1;
    nxt();
    bus.step_pulse = 1'b0;
    nxt();
    chk("mode_switch_busy", int'(bus.busy), 1);
    chk("mode_switch_phi2", int'(bus.phi2), 0);
    bus.run_mode = 1'b0;
    ce_n = 0; ce_k = -1;
    for (int k = 1; k <= 4; k++) begin
      nxt();
      if (bus.cpu_ce) begin ce_n++; ce_k = k; end
    end
    chk("mode_switch_ce_count", ce_n, 1);
    chk("mode_switch_ce_pos",   ce_k, 2);
    chk("mode_switch_idle",     int'(bus.busy), 0);
    chk("run_pulse_ignored",    int'(bus.pending), 0);

    // Pulse on the decrement edge keeps pending; reset mid-step kills the cycle.
    bus.halt = 1'b1;
    bus.step_pulse = 1'b1;
    nxt(); nxt();
    bus.step_pulse = 1'b0;
    bus.halt = 1'b0;
    chk("t6_pending_two", int'(bus.pending), 2);
    repeat (4) nxt();
    chk("t6_ce_before_dec", int'(bus.cpu_ce), 1);
    bus.step_pulse = 1'b1;
    nxt();
    bus.step_pulse = 1'b0;
    chk("t6_pending_same", int'(bus.pending), 2);
    chk("t6_still_busy",   int'(bus.busy), 1);
    nxt(); nxt();
    chk("t6_phi2_mid", int'(bus.phi2), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_ce",       int'(bus.cpu_ce),   0);
    chk("t6_rst_busy",     int'(bus.busy),     0);
    chk("t6_rst_pending",  int'(bus.pending),  0);
    chk("t6_rst_overflow", int'(bus.overflow), 0);
    nxt();
    rst = 1'b0;
    ce_n = 0;
    for (int k = 1; k <= 8; k++) begin
      nxt();
      if (bus.cpu_ce) ce_n++;
    end
    chk("t6_no_ce_after_rst", ce_n, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      nxt();
      if ($urandom_range(0, 99) < 3)  bus.run_mode = ~bus.run_mode;
      if ($urandom_range(0, 99) < 6)  bus.halt     = ~bus.halt;
      bus.step_pulse = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 999) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    nxt();
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
